// File: rtl/j1_dbus_uart_if.sv
// J1 data-bus interface: word address, single-cycle read/write strobes, 16-bit data.
// The core is the master; memory-mapped peripherals are slaves.
interface if_dbus;
    logic [15:0] adr;
    logic        re;
    logic        we;
    logic [15:0] dat_o;
    logic [15:0] dat_i;

    modport master (output adr, output re, output we, output dat_o, input dat_i);
    modport slave  (input adr, input re, input we, input dat_o, output dat_i);
endinterface

// File: rtl/j1_dbus_uart.sv
// Memory-mapped 8N1 UART on the J1 data bus: DATA / STATUS / DIV registers.
// Read data is registered and held until the next read strobe.
module j1_dbus_uart #(
    parameter logic [15:0] BASE_ADR  = 16'h7000,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic   clk,
    input  logic   reset,
    if_dbus.slave  dbus,
    input  logic   rxd,
    output logic   txd
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;

    localparam logic [DATA_W-1:0] ADR_DATA = BASE_ADR;
    localparam logic [DATA_W-1:0] ADR_STAT = BASE_ADR + 16'd1;
    localparam logic [DATA_W-1:0] ADR_DIV  = BASE_ADR + 16'd2;
    localparam logic [BIT_W-1:0]  LAST_BIT = 3'd7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    logic [DATA_W-1:0] dat_i_q;
    logic [DATA_W-1:0] div_q;

    tx_state_e         tx_state_q;
    logic [DATA_W-1:0] tx_cnt_q;
    logic [BIT_W-1:0]  tx_bit_q;
    logic [BYTE_W-1:0] tx_shift_q;
    logic              txd_q;

    rx_state_e         rx_state_q;
    logic [DATA_W-1:0] rx_cnt_q;
    logic [BIT_W-1:0]  rx_bit_q;
    logic [BYTE_W-1:0] rx_shift_q;
    logic [BYTE_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              overrun_q;
    logic              frame_err_q;
    logic              rxd_s1_q;
    logic              rxd_s2_q;
    logic              rxd_prev_q;

    logic              sel_data_c;
    logic              sel_stat_c;
    logic              sel_div_c;
    logic              rd_data_c;
    logic              rd_stat_c;
    logic              tx_ready_c;
    logic              tx_load_c;
    logic [DATA_W:0]   div_p1_c;
    logic [DATA_W-1:0] half_c;
    logic [DATA_W-1:0] rdat_d;

    // Address decode and strobe qualification
    assign sel_data_c = (dbus.adr == ADR_DATA);
    assign sel_stat_c = (dbus.adr == ADR_STAT);
    assign sel_div_c  = (dbus.adr == ADR_DIV);
    assign rd_data_c  = dbus.re && sel_data_c;
    assign rd_stat_c  = dbus.re && sel_stat_c;
    assign tx_ready_c = (tx_state_q == TX_IDLE);
    assign tx_load_c  = dbus.we && sel_data_c && tx_ready_c;

    // Half a bit period, computed one bit wider so DIV=16'hFFFF does not wrap
    assign div_p1_c = {1'b0, div_q} + 17'd1;
    assign half_c   = div_p1_c[DATA_W:1];

    // Read mux sees pre-write register values
    always_comb begin
        rdat_d = '0;
        if (sel_data_c) begin
            rdat_d = {8'h00, rx_data_q};
        end else if (sel_stat_c) begin
            rdat_d = {12'h000, frame_err_q, overrun_q, rx_valid_q, tx_ready_c};
        end else if (sel_div_c) begin
            rdat_d = div_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_i_q <= '0;
            div_q   <= DIV_RESET;
        end else begin
            if (dbus.re) begin
                dat_i_q <= rdat_d;
            end
            if (dbus.we && sel_div_c) begin
                div_q <= dbus.dat_o;
            end
        end
    end

    assign dbus.dat_i = dat_i_q;

    // Transmitter: each state holds for DIV+1 clocks, DIV sampled at every reload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (tx_load_c) begin
                        tx_shift_q <= dbus.dat_o[BYTE_W-1:0];
                        tx_cnt_q   <= div_q;
                        tx_state_q <= TX_START;
                        txd_q      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q   <= div_q;
                        tx_bit_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= div_q;
                        if (tx_bit_q == LAST_BIT) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= tx_shift_q >> 1;
                            txd_q      <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == '0) begin
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    txd_q      <= 1'b1;
                end
            endcase
        end
    end

    assign txd = txd_q;

    // Receiver; later assignments to the flags win, so completion beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_s1_q    <= 1'b1;
            rxd_s2_q    <= 1'b1;
            rxd_prev_q  <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;

            if (rd_data_c) begin
                rx_valid_q <= 1'b0;
            end
            if (rd_stat_c) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end

            unique case (rx_state_q)
                RX_IDLE: begin
                    if (!rxd_s2_q && rxd_prev_q) begin
                        rx_cnt_q   <= half_c;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rxd_s2_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_cnt_q   <= div_q;
                            rx_bit_q   <= '0;
                            rx_state_q <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_shift_q <= {rxd_s2_q, rx_shift_q[BYTE_W-1:1]};
                        rx_cnt_q   <= div_q;
                        if (rx_bit_q == LAST_BIT) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) begin
                        rx_state_q <= RX_IDLE;
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        if (!rxd_s2_q) begin
                            frame_err_q <= 1'b1;
                        end
                        if (rx_valid_q && !rd_data_c) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_j1_dbus_uart.sv
// Directed bench for j1_dbus_uart: register-access vector table plus hand-timed
// TX waveform, RX frame, same-cycle completion and reset sequences.
module tb_j1_dbus_uart;

    localparam logic [15:0] A_DATA = 16'h7000;
    localparam logic [15:0] A_STAT = 16'h7001;
    localparam logic [15:0] A_DIV  = 16'h7002;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] adr;
        logic [15:0] wd;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic rxd;
    logic txd;
    int   checks = 0;
    int   errors = 0;

    if_dbus dbus ();

    j1_dbus_uart dut (
        .clk   (clk),
        .reset (reset),
        .dbus  (dbus),
        .rxd   (rxd),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle driven from a falling edge; returns dat_i one cycle later
    task automatic bus_op(input logic we, input logic re, input logic [15:0] adr,
                          input logic [15:0] wd, output logic [15:0] rd);
        @(negedge clk);
        dbus.adr   = adr;
        dbus.we    = we;
        dbus.re    = re;
        dbus.dat_o = wd;
        @(negedge clk);
        dbus.we = 1'b0;
        dbus.re = 1'b0;
        rd      = dbus.dat_i;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] adr, input logic [15:0] exp);
        logic [15:0] d;
        bus_op(1'b0, 1'b1, adr, 16'h0, d);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [15:0] adr, input logic [15:0] wd);
        logic [15:0] d;
        bus_op(1'b1, 1'b0, adr, wd, d);
    endtask

    // 8N1 frame at 4 clocks per bit (DIV=3); call on a falling edge
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (4) @(negedge clk);
        end
        rxd = stop;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    vec_t        vt[14];
    logic [15:0] rd;
    logic [7:0]  txb;
    logic        exp_txd;

    initial begin
        reset      = 1'b1;
        rxd        = 1'b1;
        dbus.adr   = '0;
        dbus.we    = 1'b0;
        dbus.re    = 1'b0;
        dbus.dat_o = '0;

        vt[0]  = '{1'b0, 1'b1, A_DIV,    16'h0000, 1'b1, 16'd433};
        vt[1]  = '{1'b0, 1'b1, A_STAT,   16'h0000, 1'b1, 16'h0001};
        vt[2]  = '{1'b0, 1'b1, A_DATA,   16'h0000, 1'b1, 16'h0000};
        vt[3]  = '{1'b1, 1'b0, A_STAT,   16'hFFFF, 1'b0, 16'h0000};
        vt[4]  = '{1'b0, 1'b1, A_STAT,   16'h0000, 1'b1, 16'h0001};
        vt[5]  = '{1'b1, 1'b0, A_DIV,    16'hABCD, 1'b0, 16'h0000};
        vt[6]  = '{1'b0, 1'b1, A_DIV,    16'h0000, 1'b1, 16'hABCD};
        vt[7]  = '{1'b1, 1'b1, A_DIV,    16'h0003, 1'b1, 16'hABCD};
        vt[8]  = '{1'b0, 1'b0, A_DIV,    16'h0000, 1'b1, 16'hABCD};
        vt[9]  = '{1'b0, 1'b1, A_DIV,    16'h0000, 1'b1, 16'h0003};
        vt[10] = '{1'b0, 1'b1, 16'h7003, 16'h0000, 1'b1, 16'h0000};
        vt[11] = '{1'b1, 1'b0, 16'h7003, 16'h1234, 1'b0, 16'h0000};
        vt[12] = '{1'b0, 1'b1, 16'h6FFF, 16'h0000, 1'b1, 16'h0000};
        vt[13] = '{1'b0, 1'b1, A_DIV,    16'h0000, 1'b1, 16'h0003};

        idle(3);
        check("rst_txd", {15'h0, txd}, 16'h0001);
        check("rst_dat_i", dbus.dat_i, 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            bus_op(vt[i].we, vt[i].re, vt[i].adr, vt[i].wd, rd);
            if (vt[i].chk) check($sformatf("vec%0d", i), rd, vt[i].exp);
        end

        // TX 0xA5 at DIV=3, with a dropped mid-frame write and busy STATUS reads
        txb = 8'hA5;
        @(negedge clk);
        dbus.adr   = A_DATA;
        dbus.dat_o = 16'h00A5;
        dbus.we    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       exp_txd = 1'b0;
            else if (i < 36) exp_txd = txb[(i - 4) / 4];
            else             exp_txd = 1'b1;
            check($sformatf("txd_%0d", i), {15'h0, txd}, {15'h0, exp_txd});
            if (i == 16) check("tx_busy_stat", dbus.dat_i, 16'h0000);
            dbus.we = 1'b0;
            dbus.re = 1'b0;
            if (i == 5) begin
                dbus.adr   = A_DATA;
                dbus.dat_o = 16'h00FF;
                dbus.we    = 1'b1;
            end
            if (i == 15 || i == 39) begin
                dbus.adr = A_STAT;
                dbus.re  = 1'b1;
            end
            @(negedge clk);
        end
        dbus.re = 1'b0;
        check("stat_in_stop", dbus.dat_i, 16'h0000);
        check("txd_after_frame", {15'h0, txd}, 16'h0001);
        rd_chk("stat_tx_done", A_STAT, 16'h0001);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("txd_idle_%0d", i), {15'h0, txd}, 16'h0001);
            @(negedge clk);
        end

        // Single frame; TX kept busy so tx_ready reads 0
        send_frame(8'h3C, 1'b1);
        idle(12);
        wr(A_DATA, 16'h0055);
        rd_chk("rx_stat_valid", A_STAT, 16'h0002);
        rd_chk("rx_data_3c", A_DATA, 16'h003C);
        rd_chk("rx_stat_clr", A_STAT, 16'h0000);
        idle(50);

        // Overrun: two frames with no read
        send_frame(8'h11, 1'b1);
        idle(12);
        send_frame(8'h22, 1'b1);
        idle(12);
        wr(A_DATA, 16'h0055);
        rd_chk("ovr_stat", A_STAT, 16'h0006);
        rd_chk("ovr_stat_clr", A_STAT, 16'h0002);
        rd_chk("ovr_data", A_DATA, 16'h0022);
        rd_chk("ovr_stat_empty", A_STAT, 16'h0000);
        idle(50);

        // DATA read in the completion cycle: old byte, no overrun, valid stays
        send_frame(8'h44, 1'b1);
        idle(12);
        send_frame(8'h99, 1'b1);
        rd_chk("rd_at_done_old", A_DATA, 16'h0044);
        wr(A_DATA, 16'h0055);
        rd_chk("no_ovr_at_rd", A_STAT, 16'h0002);
        rd_chk("rd_at_done_new", A_DATA, 16'h0099);
        idle(50);
        rd_chk("stat_idle", A_STAT, 16'h0001);

        // STATUS read in the completion cycle of a bad-stop overrun frame
        send_frame(8'h5A, 1'b1);
        idle(12);
        send_frame(8'hC3, 1'b0);
        rd_chk("stat_at_err", A_STAT, 16'h0003);
        rd_chk("err_set_wins", A_STAT, 16'h000F);
        rd_chk("ferr_data", A_DATA, 16'h00C3);
        rd_chk("ferr_stat_clr", A_STAT, 16'h0001);

        // One-clock low glitch is a false start
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        idle(20);
        rd_chk("glitch_no_valid", A_STAT, 16'h0001);

        // Asynchronous reset in the middle of a TX frame
        wr(A_DATA, 16'h0000);
        rd_chk("div_pre_rst", A_DIV, 16'h0003);
        idle(8);
        check("txd_low_pre_rst", {15'h0, txd}, 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        check("txd_async_rst", {15'h0, txd}, 16'h0001);
        check("dat_i_async_rst", dbus.dat_i, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        check("dat_i_after_rst", dbus.dat_i, 16'h0000);
        rd_chk("stat_after_rst", A_STAT, 16'h0001);
        rd_chk("div_after_rst", A_DIV, 16'd433);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
